hazard_ctrl: RTL

- Parametrised successor to the core's forwarding/bubble logic: per-operand forwarding select across N downstream writeback stages, load-use and back-to-back memory interlock with configurable bubble count, data-memory wait freeze, and jump flush.
- Sits beside the fetch/decode and execute pipeline registers and drives PC/FD/DX enables, DX bubble injection, and the EX operand muxes.
- Adds stall/bubble performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_fwd_sel.sv | 38 +++
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// hazard_ctrl_pkg : shared types and helpers for the hazard controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } hz_state_e;

  localparam int FWD_SEL_RF = 0;

  // Select width covers code 0 (register file) plus one code per stage.
  function automatic int sel_width(input int num_stages);
    return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
// ============================================================================
// hazard_fwd_sel : priority comparator picking the nearest writeback stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int SEL_W          = 2
) (
  input  logic [REG_ADDR_W-1:0]                src_addr,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD_STAGES-1:0]            fwd_wr,
  output logic [SEL_W-1:0]                     sel
);

  logic [NUM_FWD_STAGES-1:0] hit;

  for (genvar k = 0; k < NUM_FWD_STAGES; k++) begin : g_match
    assign hit[k] = fwd_wr[k]
                 && (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] != '0)
                 && (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == src_addr);
  end

  // Walk from farthest to nearest so the nearest matching stage overrides.
  always_comb begin
    sel = SEL_W'(FWD_SEL_RF);
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (hit[k]) sel = SEL_W'(k + 1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : operand forwarding, load-use / memory interlock, dmem freeze,
//               jump flush and stall/bubble performance counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W       = 5,
  parameter int NUM_FWD_STAGES   = 2,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter bit MEM_B2B_STALL    = 1'b1,
  parameter int CNT_W            = 16
) (
  input  logic                                 clk,
  input  logic                                 n_reset,
  input  logic [REG_ADDR_W-1:0]                id_rs_addr,
  input  logic [REG_ADDR_W-1:0]                id_rd_addr,
  input  logic                                 id_uses_rs,
  input  logic                                 id_uses_rd,
  input  logic                                 id_is_mem,
  input  logic [REG_ADDR_W-1:0]                ex_rs_addr,
  input  logic [REG_ADDR_W-1:0]                ex_rd_addr,
  input  logic                                 ex_writes_rf,
  input  logic                                 ex_is_load,
  input  logic                                 ex_is_mem,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD_STAGES-1:0]            fwd_wr,
  input  logic                                 jump_now,
  input  logic                                 dmem_busy,
  input  logic                                 clear_counters,
  output logic [sel_width(NUM_FWD_STAGES)-1:0] forward_a,
  output logic [sel_width(NUM_FWD_STAGES)-1:0] forward_b,
  output logic                                 stall_fd,
  output logic                                 bubble_dx,
  output logic                                 freeze_all,
  output logic                                 flush_fd,
  output logic [CNT_W-1:0]                     stall_cycles,
  output logic [CNT_W-1:0]                     bubble_count
);

  localparam int SEL_W = sel_width(NUM_FWD_STAGES);

  hz_state_e        state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

  logic hazard_lu;
  logic hazard_mm;
  logic stall_raw, bubble_raw, freeze_raw, flush_raw;

  hazard_fwd_sel #(
    .REG_ADDR_W     (REG_ADDR_W),
    .NUM_FWD_STAGES (NUM_FWD_STAGES),
    .SEL_W          (SEL_W)
  ) u_fwd_a (
    .src_addr (ex_rs_addr),
    .fwd_rd   (fwd_rd),
    .fwd_wr   (fwd_wr),
    .sel      (forward_a)
  );

  hazard_fwd_sel #(
    .REG_ADDR_W     (REG_ADDR_W),
    .NUM_FWD_STAGES (NUM_FWD_STAGES),
    .SEL_W          (SEL_W)
  ) u_fwd_b (
    .src_addr (ex_rd_addr),
    .fwd_rd   (fwd_rd),
    .fwd_wr   (fwd_wr),
    .sel      (forward_b)
  );

  assign hazard_lu = ex_is_load && ex_writes_rf && (ex_rd_addr != '0)
                  && ((id_uses_rs && (id_rs_addr == ex_rd_addr))
                   || (id_uses_rd && (id_rd_addr == ex_rd_addr)));

  assign hazard_mm = MEM_B2B_STALL && ex_is_mem && id_is_mem;

  // Priority: dmem freeze, then jump, then interlock.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    stall_raw  = 1'b0;
    bubble_raw = 1'b0;
    freeze_raw = 1'b0;
    flush_raw  = 1'b0;
    if (dmem_busy) begin
      freeze_raw = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (jump_now) begin
            flush_raw = 1'b1;
          end else if (hazard_lu || hazard_mm) begin
            stall_raw  = 1'b1;
            bubble_raw = 1'b1;
            if (hazard_lu && (LOAD_USE_BUBBLES > 1)) begin
              state_d = LOAD_STALL;
              rem_d   = 3'(LOAD_USE_BUBBLES - 1);
            end
          end
        end
        LOAD_STALL: begin
          if (jump_now) begin
            flush_raw = 1'b1;
            state_d   = RUN;
            rem_d     = 3'd0;
          end else begin
            stall_raw  = 1'b1;
            bubble_raw = 1'b1;
            rem_d      = rem_q - 3'd1;
            if (rem_q == 3'd1) state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = 3'd0;
        end
      endcase
    end
  end

  // Control outputs are held low asynchronously while reset is asserted.
  assign stall_fd   = stall_raw  && n_reset;
  assign bubble_dx  = bubble_raw && n_reset;
  assign freeze_all = freeze_raw && n_reset;
  assign flush_fd   = flush_raw  && n_reset;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    bubble_count_d = bubble_count_q;
    if (clear_counters) begin
      stall_cycles_d = '0;
      bubble_count_d = '0;
    end else begin
      if ((stall_fd || freeze_all) && !(&stall_cycles_q))
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (bubble_dx && !(&bubble_count_q))
        bubble_count_d = bubble_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q        <= RUN;
      rem_q          <= 3'd0;
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign bubble_count = bubble_count_q;

endmodule

`default_nettype wire
